// File: rtl/rx_frame_aligner.sv
// rx_frame_aligner
//   Receive-side frame aligner in the clk_125m domain, placed after the CDC
//   FIFO. It finds the preamble (a run of 0x55 bytes) and the SFD (0xD5),
//   delimits the frame by the in_dv run, and forwards the payload bytes with
//   sof/eof/err markers. Frames longer than MAX_LEN are truncated and
//   flagged. Good and bad frames are counted.
//
//   Ports
//     clk        clk_125m domain clock
//     rst        asynchronous, active-high reset
//     in_dv      byte valid; one contiguous high run is one frame
//     in_dat     received byte
//     out_dv     payload byte valid (single-cycle pulse per byte)
//     out_dat    payload byte
//     out_sof    first payload byte of the frame
//     out_eof    last payload byte of the frame
//     out_err    frame truncated at MAX_LEN (only with out_eof)
//     out_len    payload byte count including the eof byte (only with out_eof)
//     frame_cnt  good frames delivered, saturating
//     err_cnt    rejected or truncated frames, saturating
//
//   Handshake: there is no back-pressure on either side. in_dv qualifies
//   in_dat on every clock. out_dv qualifies out_dat and the markers for
//   exactly one clock. While out_dv is low, out_dat and all markers are 0.
module rx_frame_aligner #(
   parameter int PRE_MIN = 4,
   parameter int MAX_LEN = 1536,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_dv,
   input  logic [7:0]       in_dat,
   output logic             out_dv,
   output logic [7:0]       out_dat,
   output logic             out_sof,
   output logic             out_eof,
   output logic             out_err,
   output logic [CNT_W-1:0] out_len,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int PRE_W = $clog2(PRE_MIN + 1);
   localparam logic [PRE_W-1:0] PRE_MIN_C = PRE_W'(PRE_MIN);
   localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [7:0]       PRE_BYTE  = 8'h55;
   localparam logic [7:0]       SFD_BYTE  = 8'hD5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      PAYLOAD  = 2'd2,
      DISCARD  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [PRE_W-1:0] pre_cnt;
   logic [CNT_W-1:0] len;
   logic [7:0]       hold_dat;
   logic             hold_first;
   logic             hold_vld;

   // Control strobes produced by the output-decode process.
   logic pre_ld, pre_inc, pay_start, cap, hold_clr;
   logic emit, emit_eof, emit_err;
   logic frm_inc, err_inc;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_dv) state_nxt = (in_dat == PRE_BYTE) ? PREAMBLE : DISCARD;
         end
         PREAMBLE: begin
            if (!in_dv)                                      state_nxt = IDLE;
            else if (in_dat == PRE_BYTE)                     state_nxt = PREAMBLE;
            else if (in_dat == SFD_BYTE && pre_cnt >= PRE_MIN_C) state_nxt = PAYLOAD;
            else                                             state_nxt = DISCARD;
         end
         PAYLOAD: begin
            if (!in_dv)                state_nxt = IDLE;
            else if (len == MAX_LEN_C) state_nxt = DISCARD;
         end
         DISCARD: begin
            if (!in_dv) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output / datapath control decode.
   always_comb begin
      pre_ld    = 1'b0;
      pre_inc   = 1'b0;
      pay_start = 1'b0;
      cap       = 1'b0;
      hold_clr  = 1'b0;
      emit      = 1'b0;
      emit_eof  = 1'b0;
      emit_err  = 1'b0;
      frm_inc   = 1'b0;
      err_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (in_dv) begin
               if (in_dat == PRE_BYTE) pre_ld  = 1'b1;
               else                    err_inc = 1'b1;
            end
         end
         PREAMBLE: begin
            if (!in_dv)                                          err_inc   = 1'b1;
            else if (in_dat == PRE_BYTE)                         pre_inc   = 1'b1;
            else if (in_dat == SFD_BYTE && pre_cnt >= PRE_MIN_C) pay_start = 1'b1;
            else                                                 err_inc   = 1'b1;
         end
         PAYLOAD: begin
            if (in_dv) begin
               if (len == MAX_LEN_C) begin
                  // Hold carries byte MAX_LEN; close the frame as truncated.
                  emit     = 1'b1;
                  emit_eof = 1'b1;
                  emit_err = 1'b1;
                  err_inc  = 1'b1;
                  hold_clr = 1'b1;
               end else begin
                  cap  = 1'b1;
                  emit = hold_vld;
               end
            end else begin
               hold_clr = 1'b1;
               if (hold_vld) begin
                  emit     = 1'b1;
                  emit_eof = 1'b1;
                  frm_inc  = 1'b1;
               end else begin
                  // SFD directly followed by the gap: empty payload.
                  err_inc = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Preamble counter, payload length and one-byte hold register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt    <= '0;
         len        <= '0;
         hold_dat   <= '0;
         hold_first <= 1'b0;
         hold_vld   <= 1'b0;
      end else begin
         if (pre_ld)                               pre_cnt <= PRE_W'(1);
         else if (pre_inc && pre_cnt != PRE_MIN_C) pre_cnt <= pre_cnt + PRE_W'(1);

         if (pay_start) begin
            len      <= '0;
            hold_vld <= 1'b0;
         end else if (cap) begin
            len        <= len + CNT_W'(1);
            hold_dat   <= in_dat;
            hold_first <= (len == '0);
            hold_vld   <= 1'b1;
         end else if (hold_clr) begin
            hold_vld <= 1'b0;
         end
      end
   end

   // Registered payload outputs and saturating statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_dv    <= 1'b0;
         out_dat   <= '0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         out_err   <= 1'b0;
         out_len   <= '0;
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         out_dv  <= emit;
         out_dat <= emit ? hold_dat : 8'h00;
         out_sof <= emit & hold_first;
         out_eof <= emit_eof;
         out_err <= emit_err;
         out_len <= emit_eof ? len : '0;
         if (frm_inc && frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + CNT_W'(1);
         if (err_inc && err_cnt != CNT_MAX)   err_cnt   <= err_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/rx_frame_aligner.md
Name: rx_frame_aligner

Overview:
- Single-clock successor to the PHY receive-incoming path, sitting in clk_125m after the CDC FIFO.
- Replaces fixed dv/data delay-line preamble skipping with real preamble/SFD detection, frame delimiting, a length limit and error accounting.
- Emits a clean payload byte stream with sof/eof/err markers to the UDP parser.

Parameters:
- PRE_MIN, 4, minimum count of 0x55 bytes before 0xD5 (SFD) for the frame to be accepted.
- MAX_LEN, 1536, maximum payload bytes per frame; a longer frame is truncated and flagged.
- CNT_W, 16, width of the statistics counters and the out_len field.

Ports:
- clk  in  1  clk_125m domain clock
- rst  in  1  asynchronous, active-high reset
- in_dv  in  1  byte valid; contiguous high run = one frame; a gap ends the frame
- in_dat  in  8  received byte
- out_dv  out  1  payload byte valid
- out_dat  out  8  payload byte
- out_sof  out  1  first payload byte of frame (qualified by out_dv)
- out_eof  out  1  last payload byte of frame (qualified by out_dv)
- out_err  out  1  frame truncated at MAX_LEN (valid with out_eof only)
- out_len  out  CNT_W  payload byte count including eof byte; valid with out_eof
- frame_cnt  out  CNT_W  good frames delivered (eof with err=0), saturating
- err_cnt  out  CNT_W  rejected or truncated frames, saturating

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, hold register empty, counters 0.
- States: IDLE, PREAMBLE, PAYLOAD, DISCARD. Preamble counter saturates at PRE_MIN.
- IDLE:
  - in_dv=1 and 0x55 -> PREAMBLE, pre_cnt=1.
  - in_dv=1 and any other byte -> DISCARD, err_cnt+1.
- PREAMBLE:
  - dv and 0x55 -> pre_cnt+1.
  - dv and 0xD5 with pre_cnt>=PRE_MIN -> PAYLOAD, len=0, next byte flagged first.
  - dv and 0xD5 with pre_cnt<PRE_MIN, or any other byte -> DISCARD, err_cnt+1.
  - !dv -> IDLE, err_cnt+1.
- PAYLOAD:
  - Each dv byte is captured into a 1-byte hold register with its first flag; len increments.
  - Hold full when the next byte arrives -> on that edge, register hold onto out_* with out_dv=1, out_eof=0, out_sof=first flag.
  - !dv with hold full -> emit hold with out_eof=1, out_err=0, out_len=len; frame_cnt+1; go to IDLE.
  - !dv with hold empty (SFD then gap, zero payload) -> IDLE, err_cnt+1, no output.
  - len==MAX_LEN and another dv byte -> emit hold with eof=1, err=1, out_len=MAX_LEN; err_cnt+1; DISCARD.
- DISCARD: ignore bytes until !dv, then IDLE. IDLE accepts a new frame on the very next dv cycle.
- Latency, continuous stream: byte k appears on out_* one clock after the edge capturing byte k+1. The last byte appears one clock after the first !dv edge.
- out_dv is a single-cycle pulse per byte. out_sof/out_eof/out_err/out_len are meaningful only while out_dv=1 and are 0 otherwise.
- Single-byte payload: out_sof=1 and out_eof=1 on the same cycle.
- Counters saturate at all ones and do not wrap. frame_cnt and err_cnt may both update in one cycle only from distinct events, which cannot coincide.
- Reset mid-frame: outputs clear immediately, hold is discarded, and the next frame needs a full preamble.

Test Plan:
- Good frame: 7x0x55, 0xD5, payload 0x01..0x0A, dv low -> 10 out_dv pulses with data 0x01..0x0A. sof on 0x01; eof on 0x0A with out_len=10, err=0; frame_cnt=1, err_cnt=0.
- Short preamble: 3x0x55, 0xD5, 4 bytes -> no out_dv; err_cnt=1. Then a 7x0x55 frame back-to-back with a one-cycle gap -> accepted, frame_cnt=1.
- Corrupt preamble: 0x55,0x55,0x12,... -> DISCARD until dv low; err_cnt+1, no output. Also SFD followed immediately by dv low -> err_cnt+1, no output.
- Oversize (MAX_LEN=16 in test build): 20 payload bytes -> 16 bytes out, eof with err=1 and out_len=16 on byte 16; remaining 4 dropped; err_cnt=1, frame_cnt=0.
- One-byte payload 0xAB -> single out_dv with sof=1, eof=1, len=1. Counter saturation with CNT_W=4: 17 good frames -> frame_cnt holds at 15.
- Async reset asserted mid-payload (between clock edges) -> all outputs 0 immediately. After release, the tail bytes of the interrupted frame produce no output and the next full frame is delivered intact.
